// File: rtl/cpu_mu0_delay1.sv
// cpu_mu0_delay1 -- multi-cycle MU0 accumulator CPU on a delay-1 RAM bus.
//
// Instruction word: [15:12] opcode, [11:0] operand S (word address).
// Per-instruction sequence:
//   FETCH -> EXEC          STO, JMP, JGE, JNE and STP (2 cycles)
//   FETCH -> EXEC -> EXEC2 LDA, ADD and SUB (3 cycles)
// After STP the core parks in HALT with running low until reset.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   running    high while executing, low once halted
//   address    bus word address (0 when no strobe is active)
//   write      write strobe; RAM stores writedata on this rising edge
//   read       read strobe; readdata is valid on the following cycle
//   writedata  store data, which is always ACC (0 when not writing)
//   readdata   RAM read data
//
// Build option:
//   MU0_HALT_ON_ILLEGAL_EN  opcodes 8..F halt like STP. When this is not
//                           defined, those opcodes are 2-cycle NOPs.

module cpu_mu0_delay1 #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        running,
  output logic [11:0] address,
  output logic        write,
  output logic        read,
  output logic [15:0] writedata,
  input  logic [15:0] readdata
);

  typedef enum logic [1:0] {FETCH, EXEC, EXEC2, HALT} state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  state_t      state, state_nxt;
  logic [11:0] pc, pc_nxt;
  logic [15:0] acc, acc_nxt;
  logic [15:0] ir, ir_nxt;
  logic        run_nxt;

  // During EXEC the instruction is decoded straight off the bus, because
  // IR is only loaded at the end of that cycle.
  logic [3:0]  op;
  logic [11:0] s;
  assign op = readdata[15:12];
  assign s  = readdata[11:0];

  // IR's operand field is held only for visibility; EXEC2 needs just the
  // opcode because the operand fetch was already issued in EXEC.
  logic unused_ir_s;
  assign unused_ir_s = ^ir[11:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      acc     <= '0;
      ir      <= '0;
      running <= 1'b1;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      acc     <= acc_nxt;
      ir      <= ir_nxt;
      running <= run_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    acc_nxt   = acc;
    ir_nxt    = ir;
    run_nxt   = running;
    address   = '0;
    read      = 1'b0;
    write     = 1'b0;
    writedata = '0;

    case (state)
      FETCH: begin
        address   = pc;
        read      = 1'b1;
        state_nxt = EXEC;
      end

      EXEC: begin
        ir_nxt    = readdata;
        pc_nxt    = pc + 12'd1;
        state_nxt = FETCH;
        case (op)
          OP_LDA, OP_ADD, OP_SUB: begin
            address   = s;
            read      = 1'b1;
            state_nxt = EXEC2;
          end
          OP_STO: begin
            address   = s;
            write     = 1'b1;
            writedata = acc;
          end
          OP_JMP: pc_nxt = s;
          OP_JGE: if (!acc[15]) pc_nxt = s;
          OP_JNE: if (acc != '0) pc_nxt = s;
          OP_STP: begin
            run_nxt   = 1'b0;
            state_nxt = HALT;
          end
          default: begin
`ifdef MU0_HALT_ON_ILLEGAL_EN
            run_nxt   = 1'b0;
            state_nxt = HALT;
`else
            state_nxt = FETCH;
`endif
          end
        endcase
      end

      EXEC2: begin
        state_nxt = FETCH;
        case (ir[15:12])
          OP_LDA:  acc_nxt = readdata;
          OP_ADD:  acc_nxt = acc + readdata;
          OP_SUB:  acc_nxt = acc - readdata;
          default: acc_nxt = acc;
        endcase
      end

      default: begin
        // HALT: stay frozen with both strobes low.
        state_nxt = HALT;
      end
    endcase

    // Strobes are gated directly by reset. If reset arrives mid-instruction,
    // the RAM therefore never sees a partial store.
    if (!rst) begin
      address   = '0;
      read      = 1'b0;
      write     = 1'b0;
      writedata = '0;
    end
  end

endmodule

// File: tb/tb_cpu_mu0_delay1.sv
module tb_cpu_mu0_delay1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        running, write, read;
  logic [11:0] address;
  logic [15:0] writedata, readdata;

  always #5 clk = ~clk;

  cpu_mu0_delay1 dut (
    .clk      (clk),
    .rst      (rst_n),
    .running  (running),
    .address  (address),
    .write    (write),
    .read     (read),
    .writedata(writedata),
    .readdata (readdata)
  );

  typedef struct {
    string             name;
    logic [0:7][15:0]  prog;   // words loaded at 0x000..0x007
    logic [0:3][28:0]  data;   // {valid, addr, value}, applied after prog
    int                cycles; // rising edges from reset release to running low
    logic [11:0]       chk_a;
    logic [15:0]       chk_v;
  } vec_t;

  typedef struct {
    string       name;
    int          cycles;
    logic [11:0] a;
    logic [15:0] v;
  } exp_t;

  vec_t vt[9];
  vec_t cur;
  exp_t sbq[$];
  logic load_req = 1'b0;
  logic [15:0] mem [4096];
  int n_vec = 0, n_bad = 0;

  // This is a delay-1 synchronous RAM, which is also the only writer of mem.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      for (int i = 0; i < 8; i++) mem[i] <= cur.prog[i];
      for (int i = 0; i < 4; i++)
        if (cur.data[i][28]) mem[cur.data[i][27:16]] <= cur.data[i][15:0];
    end else begin
      if (write) mem[address] <= writedata;
      if (read)  readdata <= mem[address];
    end
  end

  function automatic logic [28:0] d(input logic [11:0] a, input logic [15:0] v);
    return {1'b1, a, v};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    cur = v;
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  // This task counts edges until running falls, checking the bus rules on every cycle.
  task automatic run_to_halt(input string nm, output int cyc);
    cyc = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      cyc++;
      chk({nm, ":bus_excl"}, {31'd0, read & write}, 32'd0);
      if (!read && !write) chk({nm, ":bus_idle"}, {4'd0, address, writedata}, 32'd0);
      if (!running) break;
    end
    if (running) begin
      n_vec++; n_bad++;
      $display("FAIL %s:timeout still running after %0d cycles", nm, cyc);
    end
  endtask

  task automatic post_halt(input string nm);
    repeat (3) begin
      @(posedge clk); #1;
      chk({nm, ":halted"}, {29'd0, running, read, write}, 32'd0);
    end
  endtask

  task automatic finish_vec(input int cyc);
    exp_t e;
    e = sbq.pop_front();
    chk({e.name, ":cycles"}, cyc, e.cycles);
    chk({e.name, ":mem"}, {16'd0, mem[e.a]}, {16'd0, e.v});
    post_halt(e.name);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    rst_n = 1'b0;
    load(v);
    sbq.push_back('{v.name, v.cycles, v.chk_a, v.chk_v});
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk({v.name, ":first_fetch"}, {18'd0, read, write, address}, {18'd0, 1'b1, 1'b0, 12'h000});
    run_to_halt(v.name, cyc);
    finish_vec(cyc);
  endtask

  initial begin
    int cyc;
    vec_t rm;

    vt[0] = '{"lda_add_sto", {16'h0010,16'h2011,16'h1012,16'h7000,16'h0,16'h0,16'h0,16'h0},
              {d(12'h010,16'h0005), d(12'h011,16'h0003), 29'h0, 29'h0}, 10, 12'h012, 16'h0008};
    vt[1] = '{"countdown", {16'h0020,16'h3021,16'h1020,16'h6001,16'h7000,16'h0,16'h0,16'h0},
              {d(12'h020,16'h0003), d(12'h021,16'h0001), 29'h0, 29'h0}, 26, 12'h020, 16'h0000};
    vt[2] = '{"jge_neg", {16'h0010,16'h5004,16'h1011,16'h7000,16'h7000,16'h0,16'h0,16'h0},
              {d(12'h010,16'h8000), 29'h0, 29'h0, 29'h0}, 9, 12'h011, 16'h8000};
    vt[3] = '{"jge_zero", {16'h0010,16'h5004,16'h7000,16'h7000,16'h0012,16'h1011,16'h7000,16'h0},
              {d(12'h010,16'h0000), d(12'h012,16'h1234), 29'h0, 29'h0}, 12, 12'h011, 16'h1234};
    vt[4] = '{"add_wrap", {16'h0010,16'h2012,16'h1011,16'h7000,16'h0,16'h0,16'h0,16'h0},
              {d(12'h010,16'hFFFF), d(12'h012,16'h0001), d(12'h011,16'h5555), 29'h0}, 10, 12'h011, 16'h0000};
    vt[5] = '{"jmp_jne", {16'h4003,16'h7000,16'h7000,16'h0010,16'h6001,16'h2012,16'h1011,16'h7000},
              {d(12'h010,16'h0000), d(12'h012,16'h0007), 29'h0, 29'h0}, 14, 12'h011, 16'h0007};
    vt[6] = '{"selfmod", {16'h0010,16'h1003,16'h0011,16'h0000,16'h0,16'h0,16'h0,16'h0},
              {d(12'h010,16'h7000), d(12'h011,16'h0042), 29'h0, 29'h0}, 10, 12'h003, 16'h7000};
    vt[7] = '{"pc_wrap", {16'h0010,16'h4FFF,16'h0,16'h0,16'h0,16'h0,16'h0,16'h0},
              {d(12'h010,16'h7000), d(12'hFFF,16'h1000), 29'h0, 29'h0}, 9, 12'h000, 16'h7000};
`ifdef MU0_HALT_ON_ILLEGAL_EN
    vt[8] = '{"illegal", {16'h8000,16'h0010,16'h1011,16'h7000,16'h0,16'h0,16'h0,16'h0},
              {d(12'h010,16'hABCD), 29'h0, 29'h0, 29'h0}, 2, 12'h011, 16'h0000};
`else
    vt[8] = '{"illegal", {16'h8000,16'h0010,16'h1011,16'h7000,16'h0,16'h0,16'h0,16'h0},
              {d(12'h010,16'hABCD), 29'h0, 29'h0, 29'h0}, 9, 12'h011, 16'hABCD};
`endif

    // Check the reset state while reset is held.
    #1 rst_n = 1'b0;
    #2;
    chk("reset:outputs", {15'd0, running, read, write, address}, {15'd0, 1'b1, 1'b0, 1'b0, 12'h000});

    foreach (vt[i]) run_vec(vt[i]);

    // Assert reset during the EXEC cycle of a STO.
    rm = '{"reset_mid_sto", {16'h0010,16'h1011,16'h7000,16'h0,16'h0,16'h0,16'h0,16'h0},
           {d(12'h010,16'h1234), 29'h0, 29'h0, 29'h0}, 7, 12'h011, 16'h1234};
    rst_n = 1'b0;
    load(rm);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rmid:sto_exec", {19'd0, write, address}, {19'd0, 1'b1, 12'h011});
    #2 rst_n = 1'b0;
    #1;
    chk("rmid:strobes_off", {29'd0, running, read, write}, {29'd0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    chk("rmid:no_store", {16'd0, mem[12'h011]}, 32'd0);
    sbq.push_back('{rm.name, rm.cycles, rm.chk_a, rm.chk_v});
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rmid:refetch", {17'd0, running, read, write, address}, {17'd0, 1'b1, 1'b1, 1'b0, 12'h000});
    run_to_halt(rm.name, cyc);
    finish_vec(cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
